// File: rtl/systolic_tile.sv
// Weight-stationary N x N signed MAC tile with weight load, input skew, output deskew and command FSM.
// Optional build macro TILE_SAT_EN: saturate outputs to signed OW range instead of wrapping.
module systolic_tile #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int OW = 16,
  parameter int MW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              reuse_w,
  input  logic [MW-1:0]     m_len,
  output logic              busy,
  output logic              done,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [N*DW-1:0]   w_data,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [N*DW-1:0]   a_data,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [N*OW-1:0]   o_data
);

  localparam int AW = 2 * DW + $clog2(N);
  localparam int XW = (AW > OW) ? AW : OW;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, LOAD_W, COMPUTE, DRAIN} state_t;

  state_t        state_q;
  logic [MW-1:0] rem_q;
  logic [CW-1:0] w_cnt_q;
  logic          done_q;

  logic signed [DW-1:0] w_q    [N][N];
  logic signed [DW-1:0] w_d    [N][N];
  logic signed [DW-1:0] in_q   [N];
  logic signed [DW-1:0] in_d   [N];
  logic signed [DW-1:0] sk_q   [N][N];
  logic signed [DW-1:0] sk_d   [N][N];
  logic signed [DW-1:0] act_q  [N][N];
  logic signed [DW-1:0] act_d  [N][N];
  logic signed [AW-1:0] psum_q [N][N];
  logic signed [AW-1:0] psum_d [N][N];
  logic signed [AW-1:0] ds_q   [N][N];
  logic signed [AW-1:0] ds_d   [N][N];
  logic [2*N-1:0]       v_q;
  logic [2*N-1:0]       v_d;
  logic [OW-1:0]        o_data_q [N];
  logic [OW-1:0]        o_data_d [N];
  logic                 o_valid_q;
  logic                 o_valid_d;

  logic signed [DW-1:0] row_act [N];
  logic signed [AW-1:0] col_out [N];

  logic adv;
  logic a_fire;
  logic w_fire;
  logic pipe_empty;

  function automatic logic signed [AW-1:0] mac(input logic signed [AW-1:0] sum_in,
                                               input logic signed [DW-1:0] act,
                                               input logic signed [DW-1:0] wgt);
    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0]   prod_ext;
    prod     = act * wgt;
    prod_ext = prod;
    return sum_in + prod_ext;
  endfunction

  function automatic logic [OW-1:0] reduce_out(input logic signed [AW-1:0] acc);
    logic signed [XW-1:0] ext;
`ifdef TILE_SAT_EN
    logic signed [XW-1:0] maxv;
    logic signed [XW-1:0] minv;
`endif
    ext = acc;
`ifdef TILE_SAT_EN
    maxv = {{(XW - OW + 1){1'b0}}, {(OW - 1){1'b1}}};
    minv = ~maxv;
    if (ext > maxv) return OW'(maxv);
    if (ext < minv) return OW'(minv);
    return OW'(ext);
`else
    return OW'(ext);
`endif
  endfunction

  // The whole datapath advances together unless a held result blocks the output register.
  assign adv        = !(o_valid_q && !o_ready);
  assign w_ready    = (state_q == LOAD_W);
  assign a_ready    = (state_q == COMPUTE) && adv && (rem_q != '0);
  assign w_fire     = w_valid && w_ready;
  assign a_fire     = a_valid && a_ready;
  assign pipe_empty = (v_q == '0) && (!o_valid_q || o_ready);
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign o_valid    = o_valid_q;

  always_comb begin
    o_data = '0;
    for (int j = 0; j < N; j++) begin
      o_data[j*OW +: OW] = o_data_q[j];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      w_cnt_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            rem_q   <= m_len;
            w_cnt_q <= '0;
            state_q <= reuse_w ? COMPUTE : LOAD_W;
          end
        end
        LOAD_W: begin
          if (w_fire) begin
            w_cnt_q <= w_cnt_q + CW'(1);
            if (w_cnt_q == CW'(N - 1)) state_q <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (rem_q == '0) begin
            state_q <= DRAIN;
          end else if (a_fire) begin
            rem_q <= rem_q - MW'(1);
            if (rem_q == MW'(1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pipe_empty) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Row i enters column 0 after i extra cycles; column j leaves after N-1-j extra cycles.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      row_act[i] = (i == 0) ? in_q[0] : sk_q[i][(i == 0) ? 0 : i - 1];
    end
    for (int j = 0; j < N; j++) begin
      col_out[j] = (j == N - 1) ? psum_q[N-1][j] : ds_q[j][(j == N - 1) ? 0 : N - 2 - j];
    end
  end

  always_comb begin
    logic signed [DW-1:0] act_in;
    logic signed [AW-1:0] sum_in;
    act_in    = '0;
    sum_in    = '0;
    w_d       = w_q;
    in_d      = in_q;
    sk_d      = sk_q;
    act_d     = act_q;
    psum_d    = psum_q;
    ds_d      = ds_q;
    v_d       = v_q;
    o_data_d  = o_data_q;
    o_valid_d = o_valid_q;

    if (w_fire) begin
      for (int j = 0; j < N; j++) begin
        w_d[w_cnt_q][j] = w_data[j*DW +: DW];
      end
    end

    if (adv) begin
      for (int i = 0; i < N; i++) begin
        in_d[i]    = a_fire ? a_data[i*DW +: DW] : '0;
        sk_d[i][0] = in_q[i];
        for (int k = 1; k < N; k++) begin
          sk_d[i][k] = sk_q[i][k-1];
        end
      end

      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          act_in       = (j == 0) ? row_act[i] : act_q[i][(j == 0) ? 0 : j - 1];
          sum_in       = (i == 0) ? '0 : psum_q[(i == 0) ? 0 : i - 1][j];
          act_d[i][j]  = act_in;
          psum_d[i][j] = mac(sum_in, act_in, w_q[i][j]);
        end
      end

      for (int j = 0; j < N; j++) begin
        ds_d[j][0] = psum_q[N-1][j];
        for (int k = 1; k < N; k++) begin
          ds_d[j][k] = ds_q[j][k-1];
        end
        o_data_d[j] = reduce_out(col_out[j]);
      end

      v_d       = {v_q[2*N-2:0], a_fire};
      o_valid_d = v_q[2*N-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        in_q[i]     <= '0;
        o_data_q[i] <= '0;
        for (int j = 0; j < N; j++) begin
          w_q[i][j]    <= '0;
          sk_q[i][j]   <= '0;
          act_q[i][j]  <= '0;
          psum_q[i][j] <= '0;
          ds_q[i][j]   <= '0;
        end
      end
      v_q       <= '0;
      o_valid_q <= 1'b0;
    end else begin
      w_q       <= w_d;
      in_q      <= in_d;
      sk_q      <= sk_d;
      act_q     <= act_d;
      psum_q    <= psum_d;
      ds_q      <= ds_d;
      v_q       <= v_d;
      o_data_q  <= o_data_d;
      o_valid_q <= o_valid_d;
    end
  end

endmodule
